// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parameterised serial sequence detector.
package seq_det_pkg;

  localparam int PKG_MAX_LEN = 8;
  localparam int PKG_CNT_W   = 8;
  localparam logic [PKG_MAX_LEN-1:0] PKG_DEF_PATTERN = 8'b0000_1010;
  localparam int PKG_DEF_LEN     = 4;
  localparam int PKG_DEF_OVERLAP = 0;

  // Length field must hold 0..MAX_LEN inclusive, hence the +1.
  localparam int LEN_W = $clog2(PKG_MAX_LEN + 1);
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a synchronous clear wins over an increment.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time loadable pattern, length and overlap mode.
// z is a registered one-cycle flag following the edge that samples the completing bit.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = PKG_MAX_LEN,
  parameter int                 CNT_W       = PKG_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
  parameter int                 DEF_LEN     = PKG_DEF_LEN,
  parameter int                 DEF_OVERLAP = PKG_DEF_OVERLAP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         x,
  input  logic                         in_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic [CNT_W-1:0]             match_count
);

  localparam int             LW        = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]  MAX_LEN_L = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  mode_e              mode_q, mode_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               z_q, z_d;

  logic [MAX_LEN-1:0] histShift;
  logic [MAX_LEN-1:0] lenMask;
  logic [LW-1:0]      fillInc;
  logic               hit;
  logic               matchPulse;

  // Compare only the low len bits of the would-be history; len=0 never matches.
  always_comb begin
    histShift = {hist_q[MAX_LEN-2:0], x};
    fillInc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LW'(1);
    lenMask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenMask[i] = (i < int'(len_q));
    end
    hit = (len_q != '0) && (fillInc >= len_q) &&
          ((histShift & lenMask) == (pattern_q & lenMask));
  end

  always_comb begin
    pattern_d  = pattern_q;
    len_d      = len_q;
    mode_d     = mode_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    z_d        = 1'b0;
    matchPulse = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      mode_d    = mode_e'(cfg_overlap);
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d     = histShift;
      // Non-overlapping mode forgets the matched bits by emptying the fill.
      fill_d     = (hit && (mode_q == MODE_NON_OVERLAP)) ? '0 : fillInc;
      z_d        = hit;
      matchPulse = hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      mode_q    <= (DEF_OVERLAP != 0) ? MODE_OVERLAP : MODE_NON_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      z_q       <= z_d;
    end
  end

  assign z = z_q;

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (matchPulse),
    .count_o (match_count)
  );

endmodule
